// File: rtl/score_keeper.sv
// score_keeper: two-digit BCD score (0..MAX_SCORE) driven by count_up /
// count_down event levels, with a time-multiplexed 2-digit 7-segment display.
//
// Ports:
//   clk_1khz     in   1  system clock, all state on rising edge
//   reset        in   1  asynchronous, active-high reset
//   count_up     in   1  increment request level (counted on its rising edge)
//   count_down   in   1  decrement request level (counted on its rising edge)
//   score_tens   out  4  BCD tens digit, registered
//   score_ones   out  4  BCD ones digit, registered
//   update_o     out  1  one-cycle pulse after an edge that changed the score
//   seg_o        out  7  {g,f,e,d,c,b,a} active-high, decoded from shown digit
//   digit_sel_o  out  2  one-hot digit enable: 01 = ones, 10 = tens
//
// Configuration macro: SCORE_WRAP_EN
//   defined   : score wraps MAX_SCORE -> 00 on up and 00 -> MAX_SCORE on down
//   undefined : score saturates at both limits (default build)
module score_keeper #(
  parameter int unsigned MAX_SCORE = 99,
  parameter int unsigned MUX_DIV   = 5
) (
  input  logic       clk_1khz,
  input  logic       reset,
  input  logic       count_up,
  input  logic       count_down,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       update_o,
  output logic [6:0] seg_o,
  output logic [1:0] digit_sel_o
);

  localparam int unsigned CNT_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUX_DIV - 1);

  typedef enum logic {
    SHOW_ONES = 1'b0,
    SHOW_TENS = 1'b1
  } mux_state_t;

  logic             up_q;
  logic             dn_q;
  logic             up_ev;
  logic             dn_ev;
  logic             at_max;
  logic             at_zero;
  logic [3:0]       next_tens;
  logic [3:0]       next_ones;
  logic             score_chg;
  mux_state_t       mux_state;
  logic [CNT_W-1:0] mux_cnt;
  logic [3:0]       shown_digit;

  // Rising-edge detect so a held request counts only once
  assign up_ev   = count_up & ~up_q;
  assign dn_ev   = count_down & ~dn_q;
  assign at_max  = (score_tens == MAX_TENS) && (score_ones == MAX_ONES);
  assign at_zero = (score_tens == 4'd0) && (score_ones == 4'd0);

  // Next BCD score; simultaneous up and down cancel
  always_comb begin
    next_tens = score_tens;
    next_ones = score_ones;
    score_chg = 1'b0;
    if (up_ev && !dn_ev) begin
      if (at_max) begin
`ifdef SCORE_WRAP_EN
        next_tens = 4'd0;
        next_ones = 4'd0;
        score_chg = 1'b1;
`endif
      end else begin
        score_chg = 1'b1;
        if (score_ones == 4'd9) begin
          next_ones = 4'd0;
          next_tens = score_tens + 4'd1;
        end else begin
          next_ones = score_ones + 4'd1;
        end
      end
    end else if (dn_ev && !up_ev) begin
      if (at_zero) begin
`ifdef SCORE_WRAP_EN
        next_tens = MAX_TENS;
        next_ones = MAX_ONES;
        score_chg = 1'b1;
`endif
      end else begin
        score_chg = 1'b1;
        if (score_ones == 4'd0) begin
          next_ones = 4'd9;
          next_tens = score_tens - 4'd1;
        end else begin
          next_ones = score_ones - 4'd1;
        end
      end
    end
  end

  // Score registers, input history and update pulse
  always_ff @(posedge clk_1khz or posedge reset) begin
    if (reset) begin
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      score_tens <= 4'd0;
      score_ones <= 4'd0;
      update_o   <= 1'b0;
    end else begin
      up_q       <= count_up;
      dn_q       <= count_down;
      score_tens <= next_tens;
      score_ones <= next_ones;
      update_o   <= score_chg;
    end
  end

  // Display mux FSM: each digit held for MUX_DIV cycles
  always_ff @(posedge clk_1khz or posedge reset) begin
    if (reset) begin
      mux_state   <= SHOW_ONES;
      mux_cnt     <= '0;
      digit_sel_o <= 2'b01;
    end else if (mux_cnt == CNT_LAST) begin
      mux_cnt <= '0;
      if (mux_state == SHOW_ONES) begin
        mux_state   <= SHOW_TENS;
        digit_sel_o <= 2'b10;
      end else begin
        mux_state   <= SHOW_ONES;
        digit_sel_o <= 2'b01;
      end
    end else begin
      mux_cnt <= mux_cnt + CNT_W'(1);
    end
  end

  assign shown_digit = (mux_state == SHOW_TENS) ? score_tens : score_ones;

  // Segment decode with leading-zero blanking of the tens digit
  always_comb begin
    seg_o = 7'h00;
    if (!((mux_state == SHOW_TENS) && (score_tens == 4'd0))) begin
      case (shown_digit)
        4'd0:    seg_o = 7'h3F;
        4'd1:    seg_o = 7'h06;
        4'd2:    seg_o = 7'h5B;
        4'd3:    seg_o = 7'h4F;
        4'd4:    seg_o = 7'h66;
        4'd5:    seg_o = 7'h6D;
        4'd6:    seg_o = 7'h7D;
        4'd7:    seg_o = 7'h07;
        4'd8:    seg_o = 7'h7F;
        4'd9:    seg_o = 7'h6F;
        default: seg_o = 7'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: integer-score reference model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_score_keeper;

  localparam int unsigned MAX_SCORE = 99;
  localparam int unsigned MUX_DIV   = 5;
`ifdef SCORE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       count_up;
  logic       count_down;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic       update_o;
  logic [6:0] seg_o;
  logic [1:0] digit_sel_o;

  score_keeper #(.MAX_SCORE(MAX_SCORE), .MUX_DIV(MUX_DIV)) dut (
    .clk_1khz   (clk),
    .reset      (reset),
    .count_up   (count_up),
    .count_down (count_down),
    .score_tens (score_tens),
    .score_ones (score_ones),
    .update_o   (update_o),
    .seg_o      (seg_o),
    .digit_sel_o(digit_sel_o)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int m_score;
  bit m_up_q;
  bit m_dn_q;
  bit m_upd;
  int m_cyc;

  // Observation accumulators
  int upd_total;
  bit last_upd;
  int ones_seen_07;
  int tens_seen_blank;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  task automatic model_reset();
    m_score = 0;
    m_up_q  = 1'b0;
    m_dn_q  = 1'b0;
    m_upd   = 1'b0;
    m_cyc   = 0;
  endtask

  task automatic model_step();
    bit uev;
    bit dev;
    int ns;
    uev = count_up && !m_up_q;
    dev = count_down && !m_dn_q;
    ns  = m_score;
    if (uev && !dev)
      ns = (m_score == int'(MAX_SCORE)) ? (WRAP ? 0 : m_score) : m_score + 1;
    else if (dev && !uev)
      ns = (m_score == 0) ? (WRAP ? int'(MAX_SCORE) : 0) : m_score - 1;
    m_upd   = (ns != m_score);
    m_score = ns;
    m_up_q  = count_up;
    m_dn_q  = count_down;
    m_cyc++;
  endtask

  task automatic compare();
    int  et;
    int  eo;
    bit  show_tens;
    int  esel;
    int  eseg;
    et        = m_score / 10;
    eo        = m_score % 10;
    show_tens = ((m_cyc / int'(MUX_DIV)) % 2) == 1;
    esel      = show_tens ? 2 : 1;
    if (show_tens) eseg = (et == 0) ? 0 : int'(seg_tab[et]);
    else           eseg = int'(seg_tab[eo]);
    chk("tens", int'(score_tens), et);
    chk("ones", int'(score_ones), eo);
    chk("update", int'(update_o), int'(m_upd));
    chk("digit_sel", int'(digit_sel_o), esel);
    chk("seg", int'(seg_o), eseg);
    last_upd = update_o;
    upd_total += int'(update_o);
    if (digit_sel_o == 2'b01 && seg_o == 7'h07) ones_seen_07++;
    if (digit_sel_o == 2'b10 && seg_o == 7'h00) tens_seen_blank++;
  endtask

  // One clock: drive inputs, step model at the edge, check at the falling edge
  task automatic tick(input logic up, input logic dn);
    count_up   = up;
    count_down = dn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic pulse(input logic up, input logic dn, output bit upd);
    tick(up, dn);
    upd = last_upd;
    tick(1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, "_rst_tens"}, int'(score_tens), 0);
    chk({tag, "_rst_ones"}, int'(score_ones), 0);
    chk({tag, "_rst_upd"}, int'(update_o), 0);
    chk({tag, "_rst_sel"}, int'(digit_sel_o), 1);
    chk({tag, "_rst_seg"}, int'(seg_o), 'h3F);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit u;
    reset      = 1'b1;
    count_up   = 1'b0;
    count_down = 1'b0;
    upd_total  = 0;
    last_upd   = 1'b0;
    ones_seen_07    = 0;
    tens_seen_blank = 0;
    model_reset();
    @(negedge clk);
    do_reset("init");

    // Three separate 2-cycle up pulses
    upd_total = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
    end
    chk("t1_ones", int'(score_ones), 3);
    chk("t1_tens", int'(score_tens), 0);
    chk("t1_pulses", upd_total, 3);

    // Held input counts once
    upd_total = 0;
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("t2_ones", int'(score_ones), 4);
    chk("t2_pulses", upd_total, 1);

    // BCD carry / borrow and the lower limit
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, u);
    chk("t3_09_ones", int'(score_ones), 9);
    pulse(1'b1, 1'b0, u);
    chk("t3_10_tens", int'(score_tens), 1);
    chk("t3_10_ones", int'(score_ones), 0);
    pulse(1'b0, 1'b1, u);
    chk("t3_back_tens", int'(score_tens), 0);
    chk("t3_back_ones", int'(score_ones), 9);
    for (int i = 0; i < 9; i++) pulse(1'b0, 1'b1, u);
    chk("t3_00_ones", int'(score_ones), 0);
    pulse(1'b0, 1'b1, u);
    chk("t3_under_upd", int'(u), WRAP ? 1 : 0);
    chk("t3_under_tens", int'(score_tens), WRAP ? 9 : 0);
    chk("t3_under_ones", int'(score_ones), WRAP ? 9 : 0);

    // Upper limit
    for (int i = 0; i < 120 && m_score < int'(MAX_SCORE); i++) pulse(1'b1, 1'b0, u);
    chk("t4_99_tens", int'(score_tens), 9);
    chk("t4_99_ones", int'(score_ones), 9);
    pulse(1'b1, 1'b0, u);
    chk("t4_over_upd", int'(u), WRAP ? 1 : 0);
    chk("t4_over_tens", int'(score_tens), WRAP ? 0 : 9);
    chk("t4_over_ones", int'(score_ones), WRAP ? 0 : 9);

    // Simultaneous up and down cancel
    do_reset("t5");
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, u);
    tick(1'b1, 1'b1);
    chk("t5_both_upd", int'(last_upd), 0);
    chk("t5_both_ones", int'(score_ones), 5);
    tick(1'b0, 1'b0);

    // Mux timing and leading-zero blanking at score 07
    do_reset("t6");
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, u);
    ones_seen_07    = 0;
    tens_seen_blank = 0;
    for (int i = 0; i < 4 * int'(MUX_DIV); i++) tick(1'b0, 1'b0);
    chk("t6_ones_07", ones_seen_07, 2 * int'(MUX_DIV));
    chk("t6_tens_blank", tens_seen_blank, 2 * int'(MUX_DIV));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    do_reset("t6mid");

    // Input held high through reset release is counted once
    count_up = 1'b1;
    do_reset("t7");
    tick(1'b1, 1'b0);
    chk("t7_held_ones", int'(score_ones), 1);
    chk("t7_held_upd", int'(update_o), 1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    chk("t7_still_ones", int'(score_ones), 1);
    tick(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
